// File: rtl/t_ff_updown_counter_if.sv
// Purpose: bundles the control inputs and count outputs of t_ff_updown_counter.
// Ports:   master drives en/up/load/d and observes q/t/tc/err; slave is the counter side.
// Latency: none (wiring only).
interface t_ff_updown_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic             tc;
  logic             err;

  modport master (
    output en, up, load, d,
    input  q, t, tc, err
  );

  modport slave (
    input  en, up, load, d,
    output q, t, tc, err
  );
endinterface

// File: rtl/t_ff_updown_counter.sv
// Purpose: modulo-MOD up/down counter whose next state comes from per-bit T flip-flop toggle terms.
// Ports:   clk, rst (sync, active-low); bus.slave carries en/up/load/d in and q/t/tc/err out.
// Latency: q/err one clk after en/load are sampled; t and tc are same-cycle combinational.
module t_ff_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  t_ff_updown_counter_if.slave   bus
);

  // The modulus may equal 2**WIDTH, so the range compare needs one extra bit.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_r;
  logic             err_r;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_next;
  logic             all_ones;
  logic             all_zeros;
  logic             wrap_up;
  logic             wrap_dn;
  logic             load_ok;

  // Classic T flip-flop counter terms: bit i toggles when every lower bit is
  // 1 (counting up) or 0 (counting down). Bit 0 always toggles.
  always_comb begin
    tog       = '0;
    tog[0]    = 1'b1;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      all_ones  = all_ones & q_r[i-1];
      all_zeros = all_zeros & ~q_r[i-1];
      tog[i]    = bus.up ? all_ones : all_zeros;
    end
  end

  assign wrap_up = bus.up & (q_r == MAX_Q);
  assign wrap_dn = ~bus.up & (q_r == '0);

  // For a full binary modulus the wrap values coincide with the toggle
  // result; for a truncated modulus they override it.
  always_comb begin
    count_next = q_r ^ tog;
    if (wrap_up) begin
      count_next = '0;
    end else if (wrap_dn) begin
      count_next = MAX_Q;
    end
  end

  assign load_ok  = ({1'b0, bus.d} < MOD_W);
  assign load_val = load_ok ? bus.d : MAX_Q;

  always_comb begin
    q_next = q_r;
    if (bus.load) begin
      q_next = load_val;
    end else if (bus.en) begin
      q_next = count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next;
      err_r <= bus.load & ~load_ok;
    end
  end

  // t is the change actually applied by a count step, so it includes the
  // wrap override; loads and holds report no toggle.
  assign bus.t   = (bus.load | ~bus.en) ? '0 : (q_r ^ count_next);
  assign bus.tc  = bus.en & ~bus.load & (wrap_up | wrap_dn);
  assign bus.q   = q_r;
  assign bus.err = err_r;

endmodule

// File: tb/tb_t_ff_updown_counter.sv
module tb_t_ff_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;

  t_ff_updown_counter_if #(.WIDTH(4)) if10 ();
  t_ff_updown_counter_if #(.WIDTH(4)) if16 ();

  assign if10.en = en;  assign if10.up = up;  assign if10.load = load;  assign if10.d = d;
  assign if16.en = en;  assign if16.up = up;  assign if16.load = load;  assign if16.d = d;

  t_ff_updown_counter #(.WIDTH(4), .MOD(10)) dut10 (.clk(clk), .rst(rst), .bus(if10));
  t_ff_updown_counter #(.WIDTH(4), .MOD(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_total++;
    if (act !== 32'(exp)) begin
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: plain modular arithmetic on an integer count.
  int mq10, mq16;
  bit me10, me16;
  bit mvalid = 1'b0;

  function automatic int m_next(int mod, int q, bit r, bit e, bit u, bit l, int dv);
    if (!r)      return 0;
    if (l)       return (dv < mod) ? dv : mod - 1;
    if (e)       return u ? (q + 1) % mod : (q + mod - 1) % mod;
    return q;
  endfunction

  function automatic int m_t(int mod, int q, bit e, bit u, bit l);
    if (l || !e) return 0;
    return q ^ m_next(mod, q, 1'b1, e, u, 1'b0, 0);
  endfunction

  function automatic int m_tc(int mod, int q, bit e, bit u, bit l);
    return (e && !l && ((u && q == mod - 1) || (!u && q == 0))) ? 1 : 0;
  endfunction

  // Apply inputs mid-cycle, then check combinational outputs against the model.
  task automatic drive(input bit r, input bit e, input bit u, input bit l, input int dv);
    rst = r; en = e; up = u; load = l; d = 4'(dv);
    #2;
    if (mvalid) begin
      check("mdl_t10",  if10.t,  m_t(10, mq10, e, u, l));
      check("mdl_tc10", if10.tc, m_tc(10, mq10, e, u, l));
      check("mdl_t16",  if16.t,  m_t(16, mq16, e, u, l));
      check("mdl_tc16", if16.tc, m_tc(16, mq16, e, u, l));
    end
  endtask

  // Clock edge, advance the model, then check registered outputs.
  task automatic edge_chk();
    @(posedge clk);
    me10 = rst && load && (int'(d) >= 10);
    me16 = 1'b0;
    mq10 = m_next(10, mq10, rst, en, up, load, int'(d));
    mq16 = m_next(16, mq16, rst, en, up, load, int'(d));
    if (!rst) mvalid = 1'b1;
    #1;
    if (mvalid) begin
      check("mdl_q10",   if10.q,   mq10);
      check("mdl_err10", if10.err, me10);
      check("mdl_q16",   if16.q,   mq16);
      check("mdl_err16", if16.err, me16);
    end
  endtask

  typedef struct {
    bit       rst;
    bit       en;
    bit       up;
    bit       load;
    int       d;
    bit       chk_comb;
    int       t;
    int       tc;
    int       q;
    int       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit e, bit u, bit l, int dv, bit cc, int t, int tc, int q, int err);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.d = dv;
    v.chk_comb = cc; v.t = t; v.tc = tc; v.q = q; v.err = err;
    return v;
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = '0;

    // Directed vectors for the MOD=10 instance: inputs, pre-edge t/tc, post-edge q/err.
    //             rst en up ld  d  cc   t tc  q err
    vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0, 0, 0));  // reset, q unknown before
    vecs.push_back(mk(0, 1, 1, 0,  0, 1,  1, 0, 0, 0));  // reset held a second cycle
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  3, 0, 2, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  1, 0, 3, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  7, 0, 4, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  1, 0, 5, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  3, 0, 6, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  1, 0, 7, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1, 15, 0, 8, 0));  // 7 -> 8 toggles all bits
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  1, 0, 9, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  9, 1, 0, 0));  // up wrap 9 -> 0
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1,  2, 1,  0, 0, 2, 0));  // load 2, en/up ignored
    vecs.push_back(mk(1, 1, 0, 0,  0, 1,  3, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0,  0, 1,  1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,  0, 1,  9, 1, 9, 0));  // down wrap 0 -> 9
    vecs.push_back(mk(1, 1, 0, 0,  0, 1,  1, 0, 8, 0));
    vecs.push_back(mk(1, 0, 0, 1, 12, 1,  0, 0, 9, 1));  // out-of-range load
    vecs.push_back(mk(1, 0, 0, 0,  0, 1,  0, 0, 9, 0));  // err pulse ends
    vecs.push_back(mk(1, 1, 1, 1,  5, 1,  0, 0, 5, 0));  // load beats count
    vecs.push_back(mk(1, 0, 0, 1,  4, 1,  0, 0, 4, 0));
    vecs.push_back(mk(1, 0, 1, 0,  0, 1,  0, 0, 4, 0));  // hold x3
    vecs.push_back(mk(1, 0, 0, 0,  0, 1,  0, 0, 4, 0));
    vecs.push_back(mk(1, 0, 1, 0,  0, 1,  0, 0, 4, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  1, 0, 5, 0));  // direction flips
    vecs.push_back(mk(1, 1, 0, 0,  0, 1,  1, 0, 4, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1,  1, 0, 5, 0));
    vecs.push_back(mk(0, 1, 1, 1,  7, 1,  0, 0, 0, 0));  // reset beats load
    vecs.push_back(mk(1, 1, 0, 0,  0, 1,  9, 1, 9, 0));  // after reset, down is terminal
    vecs.push_back(mk(1, 0, 0, 1, 10, 1,  0, 0, 9, 1));  // d == MOD is out of range
    vecs.push_back(mk(1, 0, 0, 1,  9, 1,  0, 0, 9, 0));  // d == MOD-1 is legal
    vecs.push_back(mk(1, 0, 0, 1, 15, 1,  0, 0, 9, 1));
    vecs.push_back(mk(0, 0, 0, 1, 15, 1,  0, 0, 0, 0));  // reset cancels err

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].d);
      if (vecs[i].chk_comb) begin
        check($sformatf("vec%0d_t", i),  if10.t,  vecs[i].t);
        check($sformatf("vec%0d_tc", i), if10.tc, vecs[i].tc);
      end
      edge_chk();
      check($sformatf("vec%0d_q", i),   if10.q,   vecs[i].q);
      check($sformatf("vec%0d_err", i), if10.err, vecs[i].err);
    end

    // Modulus-16 instance: natural binary wrap in both directions.
    drive(1, 0, 1, 1, 13); edge_chk();
    check("m16_load13", if16.q, 13);
    drive(1, 1, 1, 0, 0);  edge_chk();
    drive(1, 1, 1, 0, 0);
    check("m16_tc_at14", if16.tc, 0);
    edge_chk();
    check("m16_q15", if16.q, 15);
    drive(1, 1, 1, 0, 0);
    check("m16_tc_at15", if16.tc, 1);
    check("m16_t_at15",  if16.t, 15);
    edge_chk();
    check("m16_wrap_q0", if16.q, 0);
    drive(1, 1, 0, 0, 0);
    check("m16_tc_dn0", if16.tc, 1);
    check("m16_t_dn0",  if16.t, 15);
    edge_chk();
    check("m16_dn_q15", if16.q, 15);
    check("m16_err",    if16.err, 0);

    // Randomized traffic checked against the model on both instances.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) != 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)));
      edge_chk();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
